// File: rtl/hazard_ctrl_pkg.sv
// Shared types and widths for the pipeline hazard controller.
// Holds the FSM encoding, register-index and counter widths, and the load-use test.
package hazard_ctrl_pkg;

   localparam int REG_IDX_W = 5;
   localparam int CNT_W     = 16;

   typedef enum logic {
      ST_RUN     = 1'b0,
      ST_MC_WAIT = 1'b1
   } state_e;

   // A load in EX whose destination feeds the instruction in ID; x0 never hazards.
   function automatic logic load_use_hazard(
      input logic                 id_valid,
      input logic                 ex_memread,
      input logic [REG_IDX_W-1:0] ex_rd,
      input logic [REG_IDX_W-1:0] rs1,
      input logic [REG_IDX_W-1:0] rs2
   );
      return id_valid & ex_memread & (ex_rd != '0) & ((ex_rd == rs1) | (ex_rd == rs2));
   endfunction

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating up-counter: counts enabled cycles, sticks at all-ones.
module sat_counter
   import hazard_ctrl_pkg::*;
#(
   parameter int W = CNT_W
) (
   input  logic         i_clk,
   input  logic         i_rst_n,
   input  logic         i_inc,
   output logic [W-1:0] o_count
);

   logic [W-1:0] r_count;
   logic         w_at_max;

   assign w_at_max = &r_count;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_count <= '0;
      end else if (i_inc && !w_at_max) begin
         r_count <= r_count + W'(1);
      end
   end

   assign o_count = r_count;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: multi-cycle stalls, load-use stalls and branch flushes,
// with saturating stall/flush event counters.
module hazard_ctrl
   import hazard_ctrl_pkg::*;
(
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 id_valid_i,
   input  logic [REG_IDX_W-1:0] id_rs1_i,
   input  logic [REG_IDX_W-1:0] id_rs2_i,
   input  logic                 id_ex_memread_i,
   input  logic [REG_IDX_W-1:0] id_ex_rd_i,
   input  logic                 ex_mc_req_i,
   input  logic                 mc_done_i,
   input  logic                 branch_taken_i,
   output logic                 pc_write_o,
   output logic                 if_id_write_o,
   output logic                 id_ex_write_o,
   output logic                 if_id_flush_o,
   output logic                 id_ex_flush_o,
   output logic                 ex_mem_bubble_o,
   output logic                 mc_start_o,
   output logic                 busy_o,
   output logic [CNT_W-1:0]     stall_cnt_o,
   output logic [CNT_W-1:0]     flush_cnt_o
);

   state_e r_state;
   state_e w_state_nxt;
   logic   w_load_use;

   assign w_load_use = load_use_hazard(id_valid_i, id_ex_memread_i, id_ex_rd_i,
                                       id_rs1_i, id_rs2_i);

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         r_state <= ST_RUN;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Priority in RUN: multi-cycle request, then load-use, then branch flush.
   always_comb begin
      w_state_nxt     = r_state;
      pc_write_o      = 1'b1;
      if_id_write_o   = 1'b1;
      id_ex_write_o   = 1'b1;
      if_id_flush_o   = 1'b0;
      id_ex_flush_o   = 1'b0;
      ex_mem_bubble_o = 1'b0;
      mc_start_o      = 1'b0;

      if (!rst_i) begin
         w_state_nxt   = ST_RUN;
         pc_write_o    = 1'b0;
         if_id_write_o = 1'b0;
         id_ex_write_o = 1'b0;
      end else begin
         case (r_state)
            ST_RUN: begin
               if (ex_mc_req_i) begin
                  mc_start_o      = 1'b1;
                  pc_write_o      = 1'b0;
                  if_id_write_o   = 1'b0;
                  id_ex_write_o   = 1'b0;
                  ex_mem_bubble_o = 1'b1;
                  w_state_nxt     = ST_MC_WAIT;
               end else if (w_load_use) begin
                  pc_write_o    = 1'b0;
                  if_id_write_o = 1'b0;
                  id_ex_flush_o = 1'b1;
               end else if (branch_taken_i) begin
                  if_id_flush_o = 1'b1;
               end
            end
            ST_MC_WAIT: begin
               if (mc_done_i) begin
                  w_state_nxt = ST_RUN;
               end else begin
                  pc_write_o      = 1'b0;
                  if_id_write_o   = 1'b0;
                  id_ex_write_o   = 1'b0;
                  ex_mem_bubble_o = 1'b1;
               end
            end
         endcase
      end
   end

   assign busy_o = (r_state == ST_MC_WAIT);

   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .i_clk   (clk_i),
      .i_rst_n (rst_i),
      .i_inc   (~pc_write_o),
      .o_count (stall_cnt_o)
   );

   sat_counter #(.W(CNT_W)) u_flush_cnt (
      .i_clk   (clk_i),
      .i_rst_n (rst_i),
      .i_inc   (if_id_flush_o),
      .o_count (flush_cnt_o)
   );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: reset, load-use, branch priority, multi-cycle wait,
// reset during wait and counter saturation.
module tb_hazard_ctrl;
   import hazard_ctrl_pkg::*;

   logic                 clk_i = 1'b0;
   logic                 rst_i;
   logic                 id_valid_i;
   logic [REG_IDX_W-1:0] id_rs1_i, id_rs2_i, id_ex_rd_i;
   logic                 id_ex_memread_i, ex_mc_req_i, mc_done_i, branch_taken_i;
   logic                 pc_write_o, if_id_write_o, id_ex_write_o;
   logic                 if_id_flush_o, id_ex_flush_o, ex_mem_bubble_o, mc_start_o, busy_o;
   logic [CNT_W-1:0]     stall_cnt_o, flush_cnt_o;

   int n_checks = 0;
   int n_errors = 0;

   // Control vector order: pc, if_id, id_ex, if_id_flush, id_ex_flush, bubble, mc_start.
   localparam logic [6:0] V_IDLE  = 7'b1110000;
   localparam logic [6:0] V_LU    = 7'b0010100;
   localparam logic [6:0] V_BR    = 7'b1111000;
   localparam logic [6:0] V_MCST  = 7'b0000011;
   localparam logic [6:0] V_MCW   = 7'b0000010;
   localparam logic [6:0] V_RST   = 7'b0000000;

   hazard_ctrl dut (
      .clk_i           (clk_i),
      .rst_i           (rst_i),
      .id_valid_i      (id_valid_i),
      .id_rs1_i        (id_rs1_i),
      .id_rs2_i        (id_rs2_i),
      .id_ex_memread_i (id_ex_memread_i),
      .id_ex_rd_i      (id_ex_rd_i),
      .ex_mc_req_i     (ex_mc_req_i),
      .mc_done_i       (mc_done_i),
      .branch_taken_i  (branch_taken_i),
      .pc_write_o      (pc_write_o),
      .if_id_write_o   (if_id_write_o),
      .id_ex_write_o   (id_ex_write_o),
      .if_id_flush_o   (if_id_flush_o),
      .id_ex_flush_o   (id_ex_flush_o),
      .ex_mem_bubble_o (ex_mem_bubble_o),
      .mc_start_o      (mc_start_o),
      .busy_o          (busy_o),
      .stall_cnt_o     (stall_cnt_o),
      .flush_cnt_o     (flush_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   function automatic logic [15:0] ctrl_vec();
      return {9'b0, pc_write_o, if_id_write_o, id_ex_write_o, if_id_flush_o,
              id_ex_flush_o, ex_mem_bubble_o, mc_start_o};
   endfunction

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Advance one edge and move just past it so inputs change away from the edge.
   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic set_idle();
      id_valid_i      = 1'b0;
      id_rs1_i        = '0;
      id_rs2_i        = '0;
      id_ex_memread_i = 1'b0;
      id_ex_rd_i      = '0;
      ex_mc_req_i     = 1'b0;
      mc_done_i       = 1'b0;
      branch_taken_i  = 1'b0;
   endtask

   task automatic set_load_use(input logic [4:0] rd);
      id_valid_i      = 1'b1;
      id_ex_memread_i = 1'b1;
      id_ex_rd_i      = rd;
      id_rs1_i        = 5'd3;
      id_rs2_i        = 5'd5;
   endtask

   initial begin
      // Reset with every hazard input active: outputs must still be all zero.
      rst_i = 1'b0;
      set_idle();
      set_load_use(5'd5);
      ex_mc_req_i    = 1'b1;
      branch_taken_i = 1'b1;
      #2;
      check("rst_ctrl_comb", ctrl_vec(), {9'b0, V_RST});
      step();
      step();
      check("rst_ctrl", ctrl_vec(), {9'b0, V_RST});
      check("rst_busy", 16'(busy_o), 16'd0);
      check("rst_stall_cnt", stall_cnt_o, 16'd0);
      check("rst_flush_cnt", flush_cnt_o, 16'd0);

      rst_i = 1'b1;
      set_idle();
      #1;
      check("idle_ctrl", ctrl_vec(), {9'b0, V_IDLE});
      step();
      check("idle_stall_cnt", stall_cnt_o, 16'd0);

      // Load-use via rs2.
      set_load_use(5'd5);
      #1;
      check("lu_ctrl", ctrl_vec(), {9'b0, V_LU});
      check("lu_cnt_before", stall_cnt_o, 16'd0);
      step();
      check("lu_cnt_after", stall_cnt_o, 16'd1);

      // rd = x0 never stalls; invalid ID never stalls; rs1 match stalls.
      set_load_use(5'd0);
      id_rs1_i = 5'd0;
      #1;
      check("lu_x0_ctrl", ctrl_vec(), {9'b0, V_IDLE});
      set_load_use(5'd3);
      id_valid_i = 1'b0;
      #1;
      check("lu_invalid_ctrl", ctrl_vec(), {9'b0, V_IDLE});
      id_valid_i = 1'b1;
      #1;
      check("lu_rs1_ctrl", ctrl_vec(), {9'b0, V_LU});
      step();
      check("lu_rs1_cnt", stall_cnt_o, 16'd2);

      // Branch together with load-use: load-use wins, no flush counted.
      set_load_use(5'd5);
      branch_taken_i = 1'b1;
      #1;
      check("prio_lu_ctrl", ctrl_vec(), {9'b0, V_LU});
      step();
      check("prio_flush_cnt", flush_cnt_o, 16'd0);
      check("prio_stall_cnt", stall_cnt_o, 16'd3);
      set_idle();
      branch_taken_i = 1'b1;
      #1;
      check("br_ctrl", ctrl_vec(), {9'b0, V_BR});
      step();
      check("br_flush_cnt", flush_cnt_o, 16'd1);
      check("br_stall_cnt", stall_cnt_o, 16'd3);

      // mc_done in RUN is ignored.
      set_idle();
      mc_done_i = 1'b1;
      #1;
      check("run_done_ctrl", ctrl_vec(), {9'b0, V_IDLE});
      step();
      check("run_done_busy", 16'(busy_o), 16'd0);

      // Multi-cycle: request at cycle 0, done at cycle 4; a branch during the wait is ignored.
      set_idle();
      ex_mc_req_i = 1'b1;
      #1;
      check("mc_c0_ctrl", ctrl_vec(), {9'b0, V_MCST});
      check("mc_c0_busy", 16'(busy_o), 16'd0);
      step();
      ex_mc_req_i = 1'b0;
      for (int c = 1; c <= 3; c++) begin
         branch_taken_i = (c == 2);
         #1;
         check($sformatf("mc_c%0d_ctrl", c), ctrl_vec(), {9'b0, V_MCW});
         check($sformatf("mc_c%0d_busy", c), 16'(busy_o), 16'd1);
         step();
      end
      branch_taken_i = 1'b0;
      mc_done_i = 1'b1;
      #1;
      check("mc_c4_ctrl", ctrl_vec(), {9'b0, V_IDLE});
      check("mc_c4_busy", 16'(busy_o), 16'd1);
      step();
      mc_done_i = 1'b0;
      check("mc_end_busy", 16'(busy_o), 16'd0);
      check("mc_stall_cnt", stall_cnt_o, 16'd7);
      check("mc_flush_cnt", flush_cnt_o, 16'd1);

      // Reset while in MC_WAIT aborts the wait; a later done has no effect.
      ex_mc_req_i = 1'b1;
      step();
      ex_mc_req_i = 1'b0;
      check("rw_busy_pre", 16'(busy_o), 16'd1);
      rst_i = 1'b0;
      branch_taken_i = 1'b1;
      #1;
      check("rw_ctrl_held", ctrl_vec(), {9'b0, V_RST});
      step();
      check("rw_busy", 16'(busy_o), 16'd0);
      check("rw_stall_cnt", stall_cnt_o, 16'd0);
      check("rw_flush_cnt", flush_cnt_o, 16'd0);
      rst_i = 1'b1;
      set_idle();
      mc_done_i = 1'b1;
      #1;
      check("rw_done_ctrl", ctrl_vec(), {9'b0, V_IDLE});
      step();
      mc_done_i = 1'b0;
      check("rw_done_busy", 16'(busy_o), 16'd0);
      check("rw_done_cnt", stall_cnt_o, 16'd0);

      // Saturation: 65535 stall cycles reach all-ones, one more must not wrap.
      set_load_use(5'd5);
      repeat (65535) step();
      check("sat_reach", stall_cnt_o, 16'hFFFF);
      step();
      check("sat_hold", stall_cnt_o, 16'hFFFF);
      set_idle();
      step();
      check("sat_idle_hold", stall_cnt_o, 16'hFFFF);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
